// File: rtl/mem_responder.sv
// Memory/IO responder for a small CPU: a program loader fills RAM while the CPU
// is held, then CPU loads and stores reach RAM, an LED register and switches.
module mem_responder #(
  parameter int         MEM_WORDS = 256,
  parameter logic [8:0] LED_ADDR  = 9'h100,
  parameter logic [8:0] SW_ADDR   = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_hold,
  output logic        bus_err
);

  localparam int         AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [9:0] MEM_LIMIT   = 10'(MEM_WORDS);
  localparam logic [7:0] LD_LAST_PTR = 8'(MEM_WORDS - 1);
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [7:0]    r_ld_ptr;
  logic [15:0]   r_read_data;
  logic [7:0]    r_led;
  logic          r_bus_err;
  logic [15:0]   r_mem [MEM_WORDS];

  logic          w_load;
  logic          w_rd;
  logic          w_wr;
  logic          w_in_ram;
  logic          w_is_sw;
  logic          w_is_led;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [15:0]   w_ram_wdata;

  assign w_load   = (r_state == ST_LOAD);
  assign w_rd     = !w_load && (mem_cmd == CMD_READ);
  assign w_wr     = !w_load && (mem_cmd == CMD_WRITE);
  assign w_in_ram = ({1'b0, mem_addr} < MEM_LIMIT);
  assign w_is_sw  = (mem_addr == SW_ADDR);
  assign w_is_led = (mem_addr == LED_ADDR);

  // Single RAM port shared by the loader (LOAD) and the CPU (RUN).
  assign w_ram_addr  = w_load ? r_ld_ptr[AW-1:0] : mem_addr[AW-1:0];
  assign w_ram_wdata = w_load ? ld_data : write_data;
  assign w_ram_we    = w_load ? ld_valid : (w_wr && w_in_ram);

  // RAM has no reset; reset only suppresses a coincident write.
  always_ff @(posedge clk) begin
    if (!reset && w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_ld_ptr    <= 8'h00;
      r_read_data <= 16'h0000;
      r_led       <= 8'h00;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (ld_valid) begin
            if (ld_last || (r_ld_ptr == LD_LAST_PTR)) begin
              r_state <= ST_RUN;
            end
            // The pointer parks on the last word instead of wrapping.
            if (r_ld_ptr != LD_LAST_PTR) begin
              r_ld_ptr <= r_ld_ptr + 8'd1;
            end
          end
        end
        ST_RUN: begin
          if (w_rd) begin
            if (w_in_ram) begin
              r_read_data <= r_mem[w_ram_addr];
            end else if (w_is_sw) begin
              r_read_data <= {8'h00, sw};
            end else begin
              r_read_data <= 16'h0000;
              r_bus_err   <= 1'b1;
            end
          end else if (w_wr) begin
            if (w_in_ram) begin
              r_read_data <= r_read_data;
            end else if (w_is_led) begin
              r_led <= write_data[7:0];
            end else begin
              r_bus_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign read_data = r_read_data;
  assign led       = r_led;
  assign bus_err   = r_bus_err;
  assign ld_ready  = w_load;
  assign cpu_hold  = w_load;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven RUN vectors plus hand-written
// load/reset sequences; expected read_data flows through a scoreboard queue.
module tb_mem_responder;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RD   = 2'b01;
  localparam logic [1:0] C_WR   = 2'b10;
  localparam logic [1:0] C_RSV  = 2'b11;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_hold;
  logic        bus_err;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  swv;
    logic [15:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[23];

  mem_responder dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .sw(sw), .led(led),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push the expected read_data, clock once, then pop and compare.
  task automatic tick_sb(input string name, input logic [15:0] exp_rd);
    logic [15:0] e;
    sb_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_rd"}, {16'h0, read_data}, {16'h0, e});
    end
  endtask

  task automatic step(input string name, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] wd, input logic [7:0] swv, input logic [15:0] exp_rd,
                      input logic exp_err, input logic [7:0] exp_led, input logic exp_hold);
    mem_cmd = cmd; mem_addr = addr; write_data = wd; sw = swv;
    tick_sb(name, exp_rd);
    chk({name, "_err"}, {31'h0, bus_err}, {31'h0, exp_err});
    chk({name, "_led"}, {24'h0, led}, {24'h0, exp_led});
    chk({name, "_hold"}, {31'h0, cpu_hold}, {31'h0, exp_hold});
  endtask

  task automatic ld_step(input string name, input logic [15:0] d, input logic last,
                         input logic [1:0] cmd, input logic [8:0] addr, input logic exp_hold);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    mem_cmd = cmd; mem_addr = addr; write_data = 16'h00FF;
    tick_sb(name, 16'h0000);
    ld_valid = 1'b0; ld_last = 1'b0;
    chk({name, "_hold"}, {31'h0, cpu_hold}, {31'h0, exp_hold});
    chk({name, "_ready"}, {31'h0, ld_ready}, {31'h0, exp_hold});
    chk({name, "_err"}, {31'h0, bus_err}, 32'd0);
    chk({name, "_led"}, {24'h0, led}, 32'd0);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_cmd = C_NONE; ld_valid = 1'b0; ld_last = 1'b0;
    chk({name, "_rd"}, {16'h0, read_data}, 32'd0);
    chk({name, "_led"}, {24'h0, led}, 32'd0);
    chk({name, "_err"}, {31'h0, bus_err}, 32'd0);
    chk({name, "_hold"}, {31'h0, cpu_hold}, 32'd1);
    chk({name, "_ready"}, {31'h0, ld_ready}, 32'd1);
  endtask

  function automatic logic [15:0] wgen(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b};
  endfunction

  initial begin
    vecs[0]  = '{C_RD,   9'h000, 16'h0000, 8'h00, 16'hD300, 1'b0, 8'h00};
    vecs[1]  = '{C_RD,   9'h001, 16'h0000, 8'h00, 16'hD10F, 1'b0, 8'h00};
    vecs[2]  = '{C_RD,   9'h002, 16'h0000, 8'h00, 16'hB183, 1'b0, 8'h00};
    vecs[3]  = '{C_WR,   9'h0A5, 16'h1234, 8'h00, 16'hB183, 1'b0, 8'h00};
    vecs[4]  = '{C_RD,   9'h0A5, 16'h0000, 8'h00, 16'h1234, 1'b0, 8'h00};
    vecs[5]  = '{C_NONE, 9'h000, 16'h0000, 8'h00, 16'h1234, 1'b0, 8'h00};
    vecs[6]  = '{C_WR,   9'h040, 16'h7777, 8'h00, 16'h1234, 1'b0, 8'h00};
    vecs[7]  = '{C_WR,   9'h0F0, 16'hAAAA, 8'h00, 16'h1234, 1'b0, 8'h00};
    vecs[8]  = '{C_RD,   9'h140, 16'h0000, 8'h5A, 16'h005A, 1'b0, 8'h00};
    vecs[9]  = '{C_WR,   9'h100, 16'hFFC3, 8'h00, 16'h005A, 1'b0, 8'hC3};
    vecs[10] = '{C_RD,   9'h000, 16'h0000, 8'h00, 16'hD300, 1'b0, 8'hC3};
    vecs[11] = '{C_RD,   9'h100, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'hC3};
    vecs[12] = '{C_RSV,  9'h0A5, 16'h9999, 8'h00, 16'h0000, 1'b0, 8'hC3};
    vecs[13] = '{C_RD,   9'h1F0, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'hC3};
    vecs[14] = '{C_NONE, 9'h000, 16'h0000, 8'h00, 16'h0000, 1'b0, 8'hC3};
    vecs[15] = '{C_WR,   9'h140, 16'hBEEF, 8'h00, 16'h0000, 1'b1, 8'hC3};
    vecs[16] = '{C_RD,   9'h040, 16'h0000, 8'h00, 16'h7777, 1'b0, 8'hC3};
    vecs[17] = '{C_WR,   9'h1F0, 16'h5555, 8'h00, 16'h7777, 1'b1, 8'hC3};
    vecs[18] = '{C_RD,   9'h0F0, 16'h0000, 8'h00, 16'hAAAA, 1'b0, 8'hC3};
    vecs[19] = '{C_RD,   9'h140, 16'h0000, 8'h81, 16'h0081, 1'b0, 8'hC3};
    vecs[20] = '{C_RD,   9'h0A5, 16'h0000, 8'h00, 16'h1234, 1'b0, 8'hC3};
    vecs[21] = '{C_WR,   9'h100, 16'h0012, 8'h00, 16'h1234, 1'b0, 8'h12};
    vecs[22] = '{C_RD,   9'h000, 16'h0000, 8'h00, 16'hD300, 1'b0, 8'h12};

    reset = 1'b1; mem_cmd = C_NONE; mem_addr = 9'h000; write_data = 16'h0000;
    sw = 8'h00; ld_valid = 1'b0; ld_data = 16'h0000; ld_last = 1'b0;
    @(posedge clk);
    do_reset("reset0");

    // Program load; CPU commands issued during LOAD must be ignored.
    ld_step("load0", 16'hD300, 1'b0, C_WR, 9'h100, 1'b1);
    ld_step("load1", 16'hD10F, 1'b0, C_RD, 9'h1F0, 1'b1);
    ld_step("load2", 16'hB183, 1'b1, C_NONE, 9'h000, 1'b0);

    for (int i = 0; i < 23; i++) begin
      step($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].swv,
           vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_led, 1'b0);
    end

    // Reset coincident with a RUN write: write discarded, back to LOAD.
    mem_cmd = C_WR; mem_addr = 9'h0A5; write_data = 16'hDEAD;
    do_reset("rst_run");

    // Reset coincident with a loader transfer after two words.
    ld_step("reload0", 16'h1111, 1'b0, C_NONE, 9'h000, 1'b1);
    ld_step("reload1", 16'h2222, 1'b0, C_NONE, 9'h000, 1'b1);
    ld_valid = 1'b1; ld_data = 16'h3333;
    do_reset("rst_load");
    ld_step("reload2", 16'hA0A0, 1'b1, C_NONE, 9'h000, 1'b0);
    step("rl_rd0",  C_RD, 9'h000, 16'h0, 8'h00, 16'hA0A0, 1'b0, 8'h00, 1'b0);
    step("rl_rd1",  C_RD, 9'h001, 16'h0, 8'h00, 16'h2222, 1'b0, 8'h00, 1'b0);
    step("rl_rd2",  C_RD, 9'h002, 16'h0, 8'h00, 16'hB183, 1'b0, 8'h00, 1'b0);
    step("rl_rdA5", C_RD, 9'h0A5, 16'h0, 8'h00, 16'h1234, 1'b0, 8'h00, 1'b0);

    // Full-length load without ld_last.
    do_reset("rst_full");
    for (int i = 0; i < 256; i++) begin
      ld_step($sformatf("full%0d", i), wgen(i), 1'b0, C_NONE, 9'h000, (i < 255) ? 1'b1 : 1'b0);
    end
    ld_valid = 1'b1; ld_data = 16'hFFFF;
    step("full_extra", C_NONE, 9'h000, 16'h0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    ld_valid = 1'b0;
    step("full_rd255", C_RD, 9'h0FF, 16'h0, 8'h00, wgen(255), 1'b0, 8'h00, 1'b0);
    step("full_rd0",   C_RD, 9'h000, 16'h0, 8'h00, wgen(0),   1'b0, 8'h00, 1'b0);
    step("full_rd128", C_RD, 9'h080, 16'h0, 8'h00, wgen(128), 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
